// File: rtl/rf_wb_pkg.sv
// Shared types and defaults for the register-file write-back arbiter.
// Optional feature macro: RF_WB_SCOREBOARD_EN (per-register pending-write mask).
package rf_wb_pkg;

    localparam int DEF_DATA_WIDTH    = 32;
    localparam int DEF_ADDRESS_WIDTH = 5;
    localparam int DEF_NUM_REGS      = 32;

    // Fill-order stamp width; entries never get more than a couple of fills
    // apart, so a small wrapping counter is enough to tell which is older.
    localparam int STAMP_W = 3;

    typedef struct packed {
        logic [DEF_ADDRESS_WIDTH-1:0] dest;
        logic [DEF_DATA_WIDTH-1:0]    data;
    } wb_req_t;

    typedef enum logic {
        WB_ALU  = 1'b0,
        WB_LOAD = 1'b1
    } wb_src_e;

    // True when slot 1 was filled strictly before slot 0 (wrap-safe compare).
    // Equal stamps mean same fill edge, which resolves in favour of slot 0.
    function automatic logic slot1_older(input logic [STAMP_W-1:0] s0,
                                         input logic [STAMP_W-1:0] s1);
        logic [STAMP_W-1:0] diff;
        diff = s0 - s1;
        return (diff != '0) && !diff[STAMP_W-1];
    endfunction

endpackage

// File: rtl/rf_wb_slot.sv
// One-entry write-back holding slot: valid/ready input, full flag, fill-age
// stamp, and silent drop of writes to x0.
module rf_wb_slot
    import rf_wb_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     valid_i,
    input  logic [ADDRESS_WIDTH-1:0] dest_i,
    input  logic [DATA_WIDTH-1:0]    data_i,
    input  logic [STAMP_W-1:0]       stamp_i,
    input  logic                     drain_i,
    output logic                     ready_o,
    output logic                     fill_o,
    output logic                     full_o,
    output logic [ADDRESS_WIDTH-1:0] dest_o,
    output logic [DATA_WIDTH-1:0]    data_o,
    output logic [STAMP_W-1:0]       stamp_o
);

    // Handshake: a transfer happens on a clock edge where valid_i && ready_o.
    // ready_o depends only on registered state (full flag and the arbiter's
    // grant), never on valid_i. A draining slot can take a new entry the same edge.
    logic                     full_q;
    logic [ADDRESS_WIDTH-1:0] dest_q;
    logic [DATA_WIDTH-1:0]    data_q;
    logic [STAMP_W-1:0]       stamp_q;

    assign ready_o = !full_q || drain_i;
    assign fill_o  = valid_i && ready_o && (dest_i != '0);
    assign full_o  = full_q;
    assign dest_o  = dest_q;
    assign data_o  = data_q;
    assign stamp_o = stamp_q;

    // Capture on a non-x0 transfer; otherwise empty when drained. An x0
    // transfer is consumed but leaves nothing behind.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            full_q  <= 1'b0;
            dest_q  <= '0;
            data_q  <= '0;
            stamp_q <= '0;
        end else if (fill_o) begin
            full_q  <= 1'b1;
            dest_q  <= dest_i;
            data_q  <= data_i;
            stamp_q <= stamp_i;
        end else if (drain_i) begin
            full_q  <= 1'b0;
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter: two requesters (0 = ALU, 1 = load) share the register
// file's single registered write port. Round-robin between different
// destinations, fill-age order between writes to the same destination.
// Optional feature macro: RF_WB_SCOREBOARD_EN adds the pending_mask output.
module rf_wb_arbiter
    import rf_wb_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
    parameter int NUM_REGS      = DEF_NUM_REGS
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [1:0]                 req_valid,
    output logic [1:0]                 req_ready,
    input  logic [2*ADDRESS_WIDTH-1:0] req_dest,
    input  logic [2*DATA_WIDTH-1:0]    req_data,
    output logic                       RegWrite,
    output logic [ADDRESS_WIDTH-1:0]   rg_wrt_dest,
    output logic [DATA_WIDTH-1:0]      rg_wrt_data,
    output logic                       grant_id,
    output logic                       wb_idle
`ifdef RF_WB_SCOREBOARD_EN
    ,
    output logic [NUM_REGS-1:0]        pending_mask
`endif
);

    logic [1:0]               full;
    logic [1:0]               fill;
    logic [1:0]               granted;
    logic [ADDRESS_WIDTH-1:0] slot_dest  [2];
    logic [DATA_WIDTH-1:0]    slot_data  [2];
    logic [STAMP_W-1:0]       slot_stamp [2];

    logic                     grant_vld;
    logic                     contested;
    wb_src_e                  grant_src;
    logic                     grant_idx;

    wb_src_e                  prio_q;
    logic [STAMP_W-1:0]       seq_q;
    logic                     regwrite_q;
    logic [ADDRESS_WIDTH-1:0] dest_q;
    logic [DATA_WIDTH-1:0]    data_q;
    logic                     gid_q;

    for (genvar gi = 0; gi < 2; gi++) begin : g_slot
        rf_wb_slot #(
            .DATA_WIDTH    (DATA_WIDTH),
            .ADDRESS_WIDTH (ADDRESS_WIDTH)
        ) u_slot (
            .clk_i   (clk),
            .rst_ni  (rst),
            .valid_i (req_valid[gi]),
            .dest_i  (req_dest[gi*ADDRESS_WIDTH +: ADDRESS_WIDTH]),
            .data_i  (req_data[gi*DATA_WIDTH +: DATA_WIDTH]),
            .stamp_i (seq_q),
            .drain_i (granted[gi]),
            .ready_o (req_ready[gi]),
            .fill_o  (fill[gi]),
            .full_o  (full[gi]),
            .dest_o  (slot_dest[gi]),
            .data_o  (slot_data[gi]),
            .stamp_o (slot_stamp[gi])
        );
    end

    // Pick the slot to drain this cycle from registered state only.
    always_comb begin
        grant_vld = full[0] || full[1];
        contested = full[0] && full[1];
        grant_src = WB_ALU;
        if (contested) begin
            if (slot_dest[0] == slot_dest[1])
                grant_src = slot1_older(slot_stamp[0], slot_stamp[1]) ? WB_LOAD : WB_ALU;
            else
                grant_src = prio_q;
        end else if (full[1]) begin
            grant_src = WB_LOAD;
        end
    end

    assign grant_idx  = grant_src;
    assign granted[0] = grant_vld && (grant_src == WB_ALU);
    assign granted[1] = grant_vld && (grant_src == WB_LOAD);

    // Round-robin priority moves away from the winner of a contested grant;
    // the fill stamp counter advances on every edge that stores an entry.
    always_ff @(posedge clk) begin
        if (!rst) begin
            prio_q <= WB_ALU;
            seq_q  <= '0;
        end else begin
            if (|fill)
                seq_q <= seq_q + 1'b1;
            if (contested)
                prio_q <= (grant_src == WB_ALU) ? WB_LOAD : WB_ALU;
        end
    end

    // Registered write port: strobe for one cycle per grant, hold address/data otherwise.
    always_ff @(posedge clk) begin
        if (!rst) begin
            regwrite_q <= 1'b0;
            dest_q     <= '0;
            data_q     <= '0;
            gid_q      <= 1'b0;
        end else if (grant_vld) begin
            regwrite_q <= 1'b1;
            dest_q     <= slot_dest[grant_idx];
            data_q     <= slot_data[grant_idx];
            gid_q      <= grant_idx;
        end else begin
            regwrite_q <= 1'b0;
        end
    end

    assign RegWrite    = regwrite_q;
    assign rg_wrt_dest = dest_q;
    assign rg_wrt_data = data_q;
    assign grant_id    = gid_q;
    assign wb_idle     = !full[0] && !full[1] && !regwrite_q;

`ifdef RF_WB_SCOREBOARD_EN
    logic [NUM_REGS-1:0] pend_q;
    logic [NUM_REGS-1:0] pend_d;

    // A register stays pending while any slot or the port still carries a
    // write to it; a new acceptance wins over a same-edge retirement.
    always_comb begin
        pend_d = pend_q;
        if (regwrite_q
            && !(full[0] && (slot_dest[0] == dest_q))
            && !(full[1] && (slot_dest[1] == dest_q)))
            pend_d[dest_q] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (fill[i])
                pend_d[req_dest[i*ADDRESS_WIDTH +: ADDRESS_WIDTH]] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    // Pending-write mask register used by issue for RAW stalls.
    always_ff @(posedge clk) begin
        if (!rst)
            pend_q <= '0;
        else
            pend_q <= pend_d;
    end

    assign pending_mask = pend_q;
`endif

endmodule
